stream_demux_1_n: RTL and testbench

- Parametrised, registered 1-to-N stream demultiplexer. Successor to the combinational 1x8 demux.
- Routes each input word to one of NUM_CH output channels using a per-word select, or to all channels in broadcast mode.
- Valid/ready handshake on both sides. Each channel has a one-entry output register.
- Sits between a single producer and NUM_CH independent consumers.

---
 rtl/stream_demux_1_n.sv | 157 +++++++++++++++
 tb/tb_stream_demux_1_n.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1_n.sv
// Registered 1-to-N stream demultiplexer.
// Each input word goes to the channel picked by s_sel, or to every channel
// when s_bcast is set. Every channel has a one-entry output register with a
// valid/ready handshake. A unicast word whose select is out of range is
// dropped and counted.

// One output channel: a single-entry buffer driven by an EMPTY/FULL FSM.
// A load always wins over a pop on the same edge, so a draining buffer can
// be refilled without a bubble.
module stream_demux_ch #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop_ready,
    output logic              can_load,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t state;
    ch_state_t state_next;

    // State register; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fill on load, drain on pop unless refilled on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (pop_ready && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign valid    = (state == FULL);
    // Free now, or being emptied by the consumer this very cycle.
    assign can_load = !valid || pop_ready;

    // Payload register; holds while stalled and keeps its old value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

endmodule

module stream_demux_1_n #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic [SEL_W-1:0]         s_sel,
    input  logic                     s_bcast,
    output logic [NUM_CH-1:0]        m_valid,
    input  logic [NUM_CH-1:0]        m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     drop_pulse
);

    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] can_load;
    logic [NUM_CH-1:0] sel_hit;
    logic [NUM_CH-1:0] load;
    logic              sel_ok;
    logic              sel_can_load;
    logic              accept;
    logic              drop;

    // Select only names a real channel when it is below NUM_CH; this can be
    // false only for non-power-of-two channel counts.
    assign sel_ok = ({1'b0, s_sel} < NUM_CH_W);

    // Readiness of the selected channel, built without indexing past NUM_CH.
    always_comb begin
        sel_can_load = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_hit[i]) sel_can_load = can_load[i];
        end
    end

    // Input ready: broadcast needs every channel, unicast needs its target,
    // and an out-of-range word is always taken so it can be dropped.
    always_comb begin
        s_ready = 1'b1;
        if (s_bcast) begin
            s_ready = &can_load;
        end else if (sel_ok) begin
            s_ready = sel_can_load;
        end
    end

    assign accept = s_valid && s_ready;
    assign drop   = accept && !s_bcast && !sel_ok;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DATA_W-1:0] ch_data;

        assign sel_hit[i] = (s_sel == SEL_W'(i));
        assign load[i]    = accept && (s_bcast || sel_hit[i]);

        stream_demux_ch #(
            .DATA_W (DATA_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (s_data),
            .pop_ready (m_ready[i]),
            .can_load  (can_load[i]),
            .valid     (m_valid[i]),
            .data      (ch_data)
        );

        assign m_data[i*DATA_W +: DATA_W] = ch_data;
    end

    // Drop reporting: registered pulse per dropped word, saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1_n.sv
// Directed bench for stream_demux_1_n: an 8-channel instance for routing,
// backpressure and broadcast, and two 6-channel instances for drop handling
// (one with a 2-bit counter to reach saturation).
module tb_stream_demux_1_n;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // 8-channel instance
    logic        s_valid8, s_ready8, s_bcast8;
    logic [7:0]  s_data8;
    logic [2:0]  s_sel8;
    logic [7:0]  m_valid8, m_ready8;
    logic [63:0] m_data8;
    logic [7:0]  drop_cnt8;
    logic        drop_pulse8;

    // 6-channel instance, 8-bit counter
    logic        s_valid6, s_ready6, s_bcast6;
    logic [7:0]  s_data6;
    logic [2:0]  s_sel6;
    logic [5:0]  m_valid6, m_ready6;
    logic [47:0] m_data6;
    logic [7:0]  drop_cnt6;
    logic        drop_pulse6;

    // 6-channel instance, 2-bit counter
    logic        s_valid6s, s_ready6s, s_bcast6s;
    logic [7:0]  s_data6s;
    logic [2:0]  s_sel6s;
    logic [5:0]  m_valid6s, m_ready6s;
    logic [47:0] m_data6s;
    logic [1:0]  drop_cnt6s;
    logic        drop_pulse6s;

    int n_checks = 0;
    int n_fail   = 0;

    stream_demux_1_n #(.DATA_W(8), .NUM_CH(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .s_valid(s_valid8), .s_ready(s_ready8),
        .s_data(s_data8), .s_sel(s_sel8), .s_bcast(s_bcast8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
        .drop_cnt(drop_cnt8), .drop_pulse(drop_pulse8)
    );

    stream_demux_1_n #(.DATA_W(8), .NUM_CH(6), .CNT_W(8)) u6 (
        .clk(clk), .rst(rst), .s_valid(s_valid6), .s_ready(s_ready6),
        .s_data(s_data6), .s_sel(s_sel6), .s_bcast(s_bcast6),
        .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
        .drop_cnt(drop_cnt6), .drop_pulse(drop_pulse6)
    );

    stream_demux_1_n #(.DATA_W(8), .NUM_CH(6), .CNT_W(2)) u6s (
        .clk(clk), .rst(rst), .s_valid(s_valid6s), .s_ready(s_ready6s),
        .s_data(s_data6s), .s_sel(s_sel6s), .s_bcast(s_bcast6s),
        .m_valid(m_valid6s), .m_ready(m_ready6s), .m_data(m_data6s),
        .drop_cnt(drop_cnt6s), .drop_pulse(drop_pulse6s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_valid8 = 0; s_bcast8 = 0; s_sel8 = 0; s_data8 = 0; m_ready8 = 8'hFF;
        s_valid6 = 0; s_bcast6 = 0; s_sel6 = 0; s_data6 = 0; m_ready6 = 6'h3F;
        s_valid6s = 0; s_bcast6s = 0; s_sel6s = 0; s_data6s = 0; m_ready6s = 6'h3F;
        step();
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (m_valid8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_m_valid got %h exp 00", m_valid8);
        end
        n_checks++;
        if (s_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL reset_s_ready got %b exp 1", s_ready8);
        end
        n_checks++;
        if (drop_cnt8 !== 8'd0 || drop_pulse8 !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop got cnt=%0d pulse=%b exp 0/0", drop_cnt8, drop_pulse8);
        end
        n_checks++;
        if (m_data8 !== 64'h0) begin
            n_fail++; $display("FAIL reset_m_data got %h exp 0", m_data8);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h00 || m_valid6 !== 6'h00 || drop_cnt6 !== 8'd0) begin
            n_fail++; $display("FAIL idle_after_reset got v8=%h v6=%h cnt6=%0d exp 00/00/0",
                               m_valid8, m_valid6, drop_cnt6);
        end
    endtask

    task automatic test_unicast_sweep();
        logic [7:0] exp_v;
        m_ready8 = 8'hFF;
        for (int n = 0; n < 8; n++) begin
            s_valid8 = 1; s_bcast8 = 0; s_sel8 = 3'(n); s_data8 = 8'hA0 + 8'(n);
            #1;
            n_checks++;
            if (s_ready8 !== 1'b1) begin
                n_fail++; $display("FAIL sweep_s_ready n=%0d got %b exp 1", n, s_ready8);
            end
            step();
            exp_v = 8'h01 << n;
            n_checks++;
            if (m_valid8 !== exp_v) begin
                n_fail++; $display("FAIL sweep_m_valid n=%0d got %h exp %h", n, m_valid8, exp_v);
            end
            n_checks++;
            if (m_data8[n*8 +: 8] !== 8'hA0 + 8'(n)) begin
                n_fail++; $display("FAIL sweep_m_data n=%0d got %h exp %h", n, m_data8[n*8 +: 8], 8'hA0 + 8'(n));
            end
        end
        s_valid8 = 0;
        step();
        n_checks++;
        if (m_valid8 !== 8'h00) begin
            n_fail++; $display("FAIL sweep_drain got %h exp 00", m_valid8);
        end
    endtask

    task automatic test_backpressure();
        m_ready8 = 8'hF7;
        s_valid8 = 1; s_bcast8 = 0; s_sel8 = 3'd3; s_data8 = 8'h11;
        #1;
        n_checks++;
        if (s_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_ready got %b exp 1", s_ready8);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h08 || m_data8[31:24] !== 8'h11) begin
            n_fail++; $display("FAIL bp_first_load got v=%h d=%h exp 08/11", m_valid8, m_data8[31:24]);
        end
        s_data8 = 8'h22;
        #1;
        n_checks++;
        if (s_ready8 !== 1'b0) begin
            n_fail++; $display("FAIL bp_second_ready got %b exp 0", s_ready8);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h08 || m_data8[31:24] !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold got v=%h d=%h exp 08/11", m_valid8, m_data8[31:24]);
        end
        m_ready8 = 8'hFF;
        #1;
        n_checks++;
        if (s_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got %b exp 1", s_ready8);
        end
        step();
        m_ready8 = 8'hF7;
        s_valid8 = 0;
        n_checks++;
        if (m_valid8 !== 8'h08 || m_data8[31:24] !== 8'h22) begin
            n_fail++; $display("FAIL bp_pop_and_load got v=%h d=%h exp 08/22", m_valid8, m_data8[31:24]);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h08 || m_data8[31:24] !== 8'h22) begin
            n_fail++; $display("FAIL bp_stall_hold got v=%h d=%h exp 08/22", m_valid8, m_data8[31:24]);
        end
    endtask

    task automatic test_broadcast();
        m_ready8 = 8'hF7;
        s_valid8 = 1; s_bcast8 = 1; s_sel8 = 3'd0; s_data8 = 8'h5A;
        #1;
        n_checks++;
        if (s_ready8 !== 1'b0) begin
            n_fail++; $display("FAIL bcast_blocked_ready got %b exp 0", s_ready8);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h08 || m_data8 !== 64'hA7A6A5A4_22A2A1A0) begin
            n_fail++; $display("FAIL bcast_no_partial got v=%h d=%h exp 08/a7a6a5a422a2a1a0", m_valid8, m_data8);
        end
        m_ready8 = 8'hFF;
        #1;
        n_checks++;
        if (s_ready8 !== 1'b1) begin
            n_fail++; $display("FAIL bcast_open_ready got %b exp 1", s_ready8);
        end
        step();
        s_valid8 = 0; s_bcast8 = 0;
        n_checks++;
        if (m_valid8 !== 8'hFF || m_data8 !== {8{8'h5A}}) begin
            n_fail++; $display("FAIL bcast_all got v=%h d=%h exp ff/5a..", m_valid8, m_data8);
        end
        step();
        n_checks++;
        if (m_valid8 !== 8'h00) begin
            n_fail++; $display("FAIL bcast_drain got %h exp 00", m_valid8);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] exp_sat;
        for (int n = 0; n < 3; n++) begin
            s_valid6 = 1; s_bcast6 = 0; s_sel6 = 3'd7; s_data6 = 8'hC0 + 8'(n);
            #1;
            n_checks++;
            if (s_ready6 !== 1'b1) begin
                n_fail++; $display("FAIL drop_ready n=%0d got %b exp 1", n, s_ready6);
            end
            step();
            n_checks++;
            if (drop_pulse6 !== 1'b1 || m_valid6 !== 6'h00) begin
                n_fail++; $display("FAIL drop_pulse n=%0d got p=%b v=%h exp 1/00", n, drop_pulse6, m_valid6);
            end
        end
        s_valid6 = 0;
        step();
        n_checks++;
        if (drop_pulse6 !== 1'b0 || drop_cnt6 !== 8'd3) begin
            n_fail++; $display("FAIL drop_count got p=%b cnt=%0d exp 0/3", drop_pulse6, drop_cnt6);
        end
        for (int n = 1; n <= 5; n++) begin
            s_valid6s = 1; s_bcast6s = 0; s_sel6s = 3'd6; s_data6s = 8'h00;
            step();
            exp_sat = (n >= 3) ? 2'd3 : 2'(n);
            n_checks++;
            if (drop_cnt6s !== exp_sat || drop_pulse6s !== 1'b1) begin
                n_fail++; $display("FAIL drop_saturate n=%0d got cnt=%0d p=%b exp %0d/1", n, drop_cnt6s, drop_pulse6s, exp_sat);
            end
        end
        s_valid6s = 0;
        step();
    endtask

    task automatic test_reset_mid();
        m_ready8 = 8'h00;
        s_valid8 = 1; s_bcast8 = 0; s_sel8 = 3'd1; s_data8 = 8'h33;
        step();
        s_sel8 = 3'd5; s_data8 = 8'h55;
        step();
        s_valid8 = 0;
        n_checks++;
        if (m_valid8 !== 8'h22 || m_data8[15:8] !== 8'h33 || m_data8[47:40] !== 8'h55) begin
            n_fail++; $display("FAIL mid_setup got v=%h d1=%h d5=%h exp 22/33/55", m_valid8, m_data8[15:8], m_data8[47:40]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (m_valid8 !== 8'h00 || m_data8 !== 64'h0) begin
            n_fail++; $display("FAIL mid_reset_state got v=%h d=%h exp 00/0", m_valid8, m_data8);
        end
        n_checks++;
        if (drop_cnt6 !== 8'd0 || drop_cnt6s !== 2'd0) begin
            n_fail++; $display("FAIL mid_reset_drop got cnt6=%0d cnt6s=%0d exp 0/0", drop_cnt6, drop_cnt6s);
        end
        m_ready8 = 8'hFF;
        s_valid8 = 1; s_sel8 = 3'd1; s_data8 = 8'h77;
        step();
        s_valid8 = 0;
        n_checks++;
        if (m_valid8 !== 8'h02 || m_data8 !== 64'h0000_0000_0000_7700) begin
            n_fail++; $display("FAIL mid_after_reset got v=%h d=%h exp 02/7700", m_valid8, m_data8);
        end
    endtask

    initial begin
        test_reset();
        test_unicast_sweep();
        test_backpressure();
        test_broadcast();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
